// File: rtl/qpoint_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the
// fixed-point synapse accumulator.
package qpoint_pkg;

  localparam int Q_INP_WIDTH  = 8;
  localparam int Q_ACC_WIDTH  = 12;
  localparam int Q_FRAC_BITS  = Q_INP_WIDTH - 1;
  localparam int Q_N_SYN      = 125;
  localparam int Q_ADDR_WIDTH = 7;

  localparam logic signed [Q_ACC_WIDTH-1:0] Q_ACC_MAX = {1'b0, {(Q_ACC_WIDTH-1){1'b1}}};
  localparam logic signed [Q_ACC_WIDTH-1:0] Q_ACC_MIN = {1'b1, {(Q_ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/qpoint_accum_ctrl_if.sv
// Control, weight-memory and result signals of the accumulator, bundled so
// the controller sees them as one slave port.
interface qpoint_accum_ctrl_if
  import qpoint_pkg::*;
#(
  parameter int INP_WIDTH  = Q_INP_WIDTH,
  parameter int ACC_WIDTH  = Q_ACC_WIDTH,
  parameter int N_SYN      = Q_N_SYN,
  parameter int ADDR_WIDTH = Q_ADDR_WIDTH
) ();

  logic                         start;
  logic [N_SYN-1:0]             spike_in;
  logic signed [ACC_WIDTH-1:0]  thresh;
  logic                         w_rd_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic signed [INP_WIDTH-1:0]  w_data;
  logic                         busy;
  logic                         done;
  logic signed [ACC_WIDTH-1:0]  acc_out;
  logic                         fire;
  logic                         sat_flag;

  modport slave (
    input  start, spike_in, thresh, w_data,
    output w_rd_en, w_addr, busy, done, acc_out, fire, sat_flag
  );

  modport master (
    output start, spike_in, thresh, w_data,
    input  w_rd_en, w_addr, busy, done, acc_out, fire, sat_flag
  );

endinterface

// File: rtl/qpoint_sat_add.sv
// Combinational signed adder: weight plus accumulator, clamped to the
// accumulator range, with a flag when the clamp engages.
module qpoint_sat_add
  import qpoint_pkg::*;
#(
  parameter int INP_WIDTH = Q_INP_WIDTH,
  parameter int ACC_WIDTH = Q_ACC_WIDTH
) (
  input  logic signed [INP_WIDTH-1:0] w_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [ACC_WIDTH-1:0] sum_o,
  output logic                        sat_o
);

  logic signed [ACC_WIDTH:0] wide;

  assign wide = {{(ACC_WIDTH+1-INP_WIDTH){w_i[INP_WIDTH-1]}}, w_i}
              + {acc_i[ACC_WIDTH-1], acc_i};

  // The top two bits disagree exactly when the result left the ACC range.
  assign sat_o = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];

  always_comb begin
    sum_o = wide[ACC_WIDTH-1:0];
    if (sat_o) begin
      sum_o = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/qpoint_accum_ctrl.sv
// Walks all synapse weights once per start, accumulating those whose spike
// bit is set, then compares the membrane potential against the threshold.
module qpoint_accum_ctrl
  import qpoint_pkg::*;
#(
  parameter int INP_WIDTH  = Q_INP_WIDTH,
  parameter int ACC_WIDTH  = Q_ACC_WIDTH,
  parameter int N_SYN      = Q_N_SYN,
  parameter int ADDR_WIDTH = Q_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  qpoint_accum_ctrl_if.slave bus
);

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       idx_q, idx_d;
  logic [N_SYN-1:0]            spk_q, spk_d;
  logic signed [ACC_WIDTH-1:0] thresh_q, thresh_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic                        fire_q, fire_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        vld_q;
  logic                        rd_en;
  logic [ADDR_WIDTH-1:0]       addr;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        sum_sat;

  qpoint_sat_add #(
    .INP_WIDTH (INP_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .w_i   (bus.w_data),
    .acc_i (acc_q),
    .sum_o (sum),
    .sat_o (sum_sat)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    spk_d    = spk_q;
    thresh_d = thresh_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    fire_d   = fire_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    addr     = '0;

    // vld_q marks the cycle in which w_data answers last cycle's read.
    if (vld_q) begin
      acc_d = sum;
      sat_d = sat_q | sum_sat;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          spk_d    = bus.spike_in;
          thresh_d = bus.thresh;
          acc_d    = '0;
          sat_d    = 1'b0;
          fire_d   = 1'b0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        addr  = idx_q;
        rd_en = spk_q[idx_q];
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_WIDTH'(N_SYN - 1)) begin
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        fire_d  = (acc_q >= thresh_q);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      spk_q    <= '0;
      thresh_q <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      fire_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      spk_q    <= spk_d;
      thresh_q <= thresh_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      fire_q   <= fire_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      vld_q    <= rd_en;
    end
  end

  assign bus.w_rd_en  = rd_en;
  assign bus.w_addr   = addr;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_out  = acc_q;
  assign bus.fire     = fire_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_qpoint_accum_ctrl.sv
// Directed bench: stimulus pushes expected results into a scoreboard queue,
// a monitor pops and compares them on every done pulse.
module tb_qpoint_accum_ctrl;

  localparam int N = 125;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qpoint_accum_ctrl_if #(.INP_WIDTH(8), .ACC_WIDTH(12), .N_SYN(N), .ADDR_WIDTH(7)) bus ();

  qpoint_accum_ctrl #(.INP_WIDTH(8), .ACC_WIDTH(12), .N_SYN(N), .ADDR_WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic signed [7:0] w_mem [0:127];

  // Weight RAM with registered read; junk on the bus when not enabled.
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= w_mem[bus.w_addr];
    else             bus.w_data <= 8'($urandom);
  end

  typedef struct {
    string name;
    int    acc;
    int    fire;
    int    sat;
    int    rd_cnt;
    int    rd_addr;
    int    accept_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rd_cnt   = 0;
  int   rd_addr  = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        rd_cnt  = 0;
        rd_addr = -1;
      end else begin
        if (bus.w_rd_en) begin
          if (rd_cnt == 0) rd_addr = int'(bus.w_addr);
          rd_cnt++;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_acc"},     int'(bus.acc_out), e.acc);
            check({e.name, "_fire"},    int'(bus.fire), e.fire);
            check({e.name, "_sat"},     int'(bus.sat_flag), e.sat);
            check({e.name, "_latency"}, cyc - e.accept_cyc, 127);
            check({e.name, "_rd_cnt"},  rd_cnt, e.rd_cnt);
            check({e.name, "_rd_addr"}, rd_addr, e.rd_addr);
            $display("txn %s acc=%0d fire=%0d sat=%0d reads=%0d", e.name,
                     bus.acc_out, bus.fire, bus.sat_flag, rd_cnt);
          end
          rd_cnt  = 0;
          rd_addr = -1;
        end
      end
    end
  end

  task automatic fill(input int v);
    for (int i = 0; i < 128; i++) w_mem[i] = 8'(v);
  endtask

  // Issues one start, then scrambles spike_in/thresh to prove they were latched.
  task automatic issue(input logic [N-1:0] spk, input int th, output int acc_cyc);
    @(negedge clk);
    bus.spike_in = spk;
    bus.thresh   = 12'(th);
    bus.start    = 1'b1;
    acc_cyc      = cyc + 1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.spike_in = ~spk;
    bus.thresh   = 12'($urandom);
  endtask

  task automatic run(input string name, input logic [N-1:0] spk, input int th,
                     input int acc, input int fire, input int sat,
                     input int rdc, input int rda);
    exp_t e;
    int   ac;
    e.name = name; e.acc = acc; e.fire = fire; e.sat = sat;
    e.rd_cnt = rdc; e.rd_addr = rda;
    // Push before the start edge so the monitor always finds it in time.
    @(negedge clk);
    e.accept_cyc = cyc + 2;
    sb.push_back(e);
    issue(spk, th, ac);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [N-1:0] one5;
  int           ac;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.spike_in = '0;
    bus.thresh   = '0;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_done",  int'(bus.done), 0);
    check("reset_acc",   int'(bus.acc_out), 0);
    check("reset_fire",  int'(bus.fire), 0);
    check("reset_sat",   int'(bus.sat_flag), 0);
    check("reset_rd_en", int'(bus.w_rd_en), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(5);
    run("no_spikes", '0, 0, 0, 1, 0, 0, -1);
    wait_empty();

    fill(1);
    run("ones_th125", '1, 125, 125, 1, 0, N, 0);
    wait_empty();
    run("ones_th126", '1, 126, 125, 0, 0, N, 0);
    wait_empty();

    fill(127);
    run("sat_pos", '1, 0, 2047, 1, 1, N, 0);
    wait_empty();
    fill(-128);
    run("sat_neg", '1, 0, -2048, 0, 1, N, 0);
    wait_empty();

    fill(127);
    w_mem[5] = 8'sd64;
    one5     = '0;
    one5[5]  = 1'b1;
    run("spike5", one5, 64, 64, 1, 0, 1, 5);
    wait_empty();

    // Extra starts in RUN, DRAIN and DONE must be dropped.
    fill(1);
    run("extra_start", '1, 125, 125, 1, 0, N, 0);
    ac = cyc;
    while (cyc < ac + 10) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    while (cyc < ac + 125) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); @(negedge clk); bus.start = 1'b0;
    wait_empty();
    repeat (140) @(negedge clk);
    check("extra_start_busy_idle", int'(bus.busy), 0);

    // Abort mid-run: idx 40 is on the address bus in the cycle after edge accept+40.
    issue('1, 0, ac);
    while (cyc < ac + 40) @(negedge clk);
    check("pre_reset_addr", int'(bus.w_addr), 40);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  int'(bus.busy), 0);
    check("abort_acc",   int'(bus.acc_out), 0);
    check("abort_rd_en", int'(bus.w_rd_en), 0);
    check("abort_addr",  int'(bus.w_addr), 0);
    check("abort_done",  int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    check("abort_no_busy", int'(bus.busy), 0);

    run("after_abort", '1, 0, 125, 1, 0, N, 0);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpoint_accum_ctrl.md
Name: qpoint_accum_ctrl

Overview:
Sequencer that owns one saturating fixed-point adder and drives a synchronous weight memory. On start it walks all N_SYN synapse weights, one per cycle. It accumulates each weight whose presynaptic spike bit is set into a membrane-potential register. It then compares the result against a threshold and reports fire/done. It sits between the per-neuron weight RAM (signed Q1.7 weights) and the spike/neuron update logic of the SNN layer.

Parameters:
INP_WIDTH, 8, signed weight width (Q1.7, FRAC_BITS = INP_WIDTH-1)
ACC_WIDTH, 12, signed accumulator width, same fractional point as weights
N_SYN, 125, synapses per neuron
ADDR_WIDTH, 7, weight address width, must satisfy 2**ADDR_WIDTH >= N_SYN

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
spike_in  in  N_SYN  presynaptic spike vector, latched on accepted start
thresh  in  ACC_WIDTH  signed firing threshold, latched on accepted start
w_rd_en  out  1  weight memory read enable
w_addr  out  ADDR_WIDTH  weight memory address
w_data  in  INP_WIDTH  signed weight, valid exactly 1 cycle after w_rd_en
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse, result valid
acc_out  out  ACC_WIDTH  signed accumulated potential, held until next start
fire  out  1  acc_out >= thresh (signed), held until next start
sat_flag  out  1  set if any add saturated during the run, held until next start

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, latched spike/thresh 0. Reset is asynchronous and clears a run in progress; no done pulse follows.
- FSM states and transitions:
  - IDLE: start=1 latches spike_in and thresh, clears acc/sat_flag/fire, sets idx=0, goes to RUN.
  - RUN: each cycle drives w_addr=idx and w_rd_en=spk[idx]; increments idx. After issuing idx=N_SYN-1, goes to DRAIN.
  - DRAIN: one cycle in which the last read's data is accumulated; then goes to DONE.
  - DONE: done=1 for one cycle, fire=(acc>=thresh); then goes to IDLE.
- w_addr is 0 outside RUN.
- Read pipeline: a 1-bit valid register (previous w_rd_en) gates accumulation. acc += sext(w_data) when valid=1. No add occurs for zero spike bits.
- Arithmetic: the sign-extended weight is added to acc in ACC_WIDTH+1 bits, then saturated to [-2**(ACC_WIDTH-1), 2**(ACC_WIDTH-1)-1]. On clamp, sat_flag is set (sticky for the run).
- Latency: an accepted start at edge 0 gives done high in the cycle after edge N_SYN+2 (127 cycles for defaults). Latency is independent of the spike pattern.
- start while busy or in DONE is ignored (not queued).
- start in the same cycle as DONE's exit is ignored; the next start is accepted in IDLE.
- spike_in and thresh changes after latching have no effect on the run in progress.

Decomposition:
- Shared package qpoint_pkg: INP_WIDTH/ACC_WIDTH/FRAC_BITS defaults, the state enum (IDLE, RUN, DRAIN, DONE), and the saturation min/max constants.
- One sub-module, qpoint_sat_add: combinational signed saturating adder (INP_WIDTH + ACC_WIDTH -> ACC_WIDTH, sat out). It is instantiated once and shared across all synapses.

Test Plan:
- All spikes 0, thresh=0, start -> w_rd_en never high; done exactly 127 cycles after start; acc_out=0; fire=1; sat_flag=0.
- All spikes 1, w[i]=8'sd1 -> acc_out=125 (0x07D), fire=1 with thresh=125, fire=0 with thresh=126, sat_flag=0.
- All spikes 1, w[i]=127 -> acc_out=2047, sat_flag=1. Repeat with w[i]=-128 -> acc_out=-2048, sat_flag=1, fire=0 with thresh=0.
- Only spike bit 5 set, w[5]=64 (0.5), other weights 127 -> exactly one w_rd_en pulse at w_addr=5; acc_out=64; fire=1 with thresh=64.
- Extra start pulses at cycles 10 and 126 of a run -> ignored; exactly one done pulse; result unchanged.
- rst_n low at idx=40 -> all outputs 0 immediately, no done pulse. A subsequent start completes normally with the expected result.
